// File: rtl/coin_feeder_if.sv
// coin_feeder_if
//   Bundles the purchase request, vending machine feedback and the coin
//   feeder outputs into one connection.
//   master : drives start, plan, newspaper; observes coin, busy, done,
//            timeout, error, paid (the controlling side / testbench).
//   slave  : the coin_feeder itself.
interface coin_feeder_if;
    logic       start;
    logic [1:0] plan;
    logic       newspaper;
    logic [1:0] coin;
    logic       busy;
    logic       done;
    logic       timeout;
    logic       error;
    logic [4:0] paid;

    modport master (
        output start, plan, newspaper,
        input  coin, busy, done, timeout, error, paid
    );

    modport slave (
        input  start, plan, newspaper,
        output coin, busy, done, timeout, error, paid
    );
endinterface

// File: rtl/coin_feeder.sv
// coin_feeder
//   Feeds a sequence of nickels/dimes into a vending machine according to a
//   two-bit payment plan, then waits for the newspaper to be dispensed.
//   Ports:
//     clock : rising-edge clock
//     reset : synchronous, active-low reset
//     bus   : coin_feeder_if.slave
//             start/plan/newspaper in; coin, busy, done, timeout, error,
//             paid out (all registered)
//   Parameters:
//     HOLD_CYCLES : cycles each coin code is held on coin (>= 1)
//     GAP_CYCLES  : cycles coin is held at 0 after each coin (>= 1)
//     WAIT_CYCLES : cycles allowed for the newspaper after the final gap (>= 1)
module coin_feeder #(
    parameter int HOLD_CYCLES = 1,
    parameter int GAP_CYCLES  = 2,
    parameter int WAIT_CYCLES = 4
) (
    input  logic         clock,
    input  logic         reset,
    coin_feeder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE   = 2'd0;
    localparam logic [1:0] COIN_NICKEL = 2'd1;
    localparam logic [1:0] COIN_DIME   = 2'd2;

    // One shared phase counter; it only has to reach the largest window - 1.
    localparam int CNT_MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_HG > WAIT_CYCLES) ? CNT_MAX_HG : WAIT_CYCLES;
    localparam int CW         = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);

    // Coin code for position idx of a plan.
    function automatic logic [1:0] coin_code(input logic [1:0] plan, input logic [1:0] idx);
        logic [1:0] code;
        case (plan)
            2'd0:    code = COIN_NICKEL;
            2'd1:    code = (idx == 2'd0) ? COIN_NICKEL : COIN_DIME;
            2'd2:    code = (idx == 2'd0) ? COIN_DIME : COIN_NICKEL;
            2'd3:    code = COIN_DIME;
            default: code = COIN_NONE;
        endcase
        return code;
    endfunction

    // Value in cents of a coin code.
    function automatic logic [4:0] coin_value(input logic [1:0] code);
        logic [4:0] cents;
        case (code)
            COIN_NICKEL: cents = 5'd5;
            COIN_DIME:   cents = 5'd10;
            default:     cents = 5'd0;
        endcase
        return cents;
    endfunction

    // Index of the final coin: plan 0 uses three nickels, the others two coins.
    function automatic logic [1:0] last_idx(input logic [1:0] plan);
        logic [1:0] idx;
        if (plan == 2'd0) begin
            idx = 2'd2;
        end else begin
            idx = 2'd1;
        end
        return idx;
    endfunction

    state_t        state_r, state_s;
    logic [1:0]    plan_r, plan_s;
    logic [1:0]    idx_r, idx_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [1:0]    coin_r, coin_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          timeout_r, timeout_s;
    logic          error_r, error_s;
    logic [4:0]    paid_r, paid_s;
    logic          last_s;
    logic [1:0]    next_code_s;

    // Next-state and next-output logic; every output is computed here and
    // registered below so the pins never see combinational paths.
    always_comb begin
        state_s     = state_r;
        plan_s      = plan_r;
        idx_s       = idx_r;
        cnt_s       = cnt_r;
        coin_s      = coin_r;
        paid_s      = paid_r;
        done_s      = 1'b0;
        timeout_s   = 1'b0;
        error_s     = 1'b0;
        last_s      = (idx_r == last_idx(plan_r));
        next_code_s = coin_code(plan_r, idx_r + 2'd1);

        case (state_r)
            IDLE: begin
                coin_s = COIN_NONE;
                if (bus.start) begin
                    plan_s  = bus.plan;
                    idx_s   = 2'd0;
                    cnt_s   = '0;
                    coin_s  = coin_code(bus.plan, 2'd0);
                    paid_s  = coin_value(coin_code(bus.plan, 2'd0));
                    state_s = DRIVE;
                end else begin
                    cnt_s = '0;
                end
            end

            DRIVE: begin
                if (bus.newspaper) begin
                    // Dispensed while the final coin is on the bus counts as
                    // success; any earlier coin means the machine misbehaved.
                    coin_s  = COIN_NONE;
                    cnt_s   = '0;
                    state_s = IDLE;
                    if (last_s) begin
                        done_s = 1'b1;
                    end else begin
                        error_s = 1'b1;
                    end
                end else if (cnt_r == HOLD_LAST) begin
                    coin_s  = COIN_NONE;
                    cnt_s   = '0;
                    state_s = GAP;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end

            GAP: begin
                if (bus.newspaper) begin
                    coin_s  = COIN_NONE;
                    cnt_s   = '0;
                    state_s = IDLE;
                    if (last_s) begin
                        done_s = 1'b1;
                    end else begin
                        error_s = 1'b1;
                    end
                end else if (cnt_r == GAP_LAST) begin
                    cnt_s = '0;
                    if (last_s) begin
                        state_s = WAIT;
                    end else begin
                        idx_s   = idx_r + 2'd1;
                        coin_s  = next_code_s;
                        paid_s  = paid_r + coin_value(next_code_s);
                        state_s = DRIVE;
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end

            WAIT: begin
                coin_s = COIN_NONE;
                if (bus.newspaper) begin
                    done_s  = 1'b1;
                    cnt_s   = '0;
                    state_s = IDLE;
                end else if (cnt_r == WAIT_LAST) begin
                    timeout_s = 1'b1;
                    cnt_s     = '0;
                    state_s   = IDLE;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end

            default: begin
                coin_s  = COIN_NONE;
                cnt_s   = '0;
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State, counters and registered outputs; reset aborts silently.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r   <= IDLE;
            plan_r    <= 2'd0;
            idx_r     <= 2'd0;
            cnt_r     <= '0;
            coin_r    <= COIN_NONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            error_r   <= 1'b0;
            paid_r    <= 5'd0;
        end else begin
            state_r   <= state_s;
            plan_r    <= plan_s;
            idx_r     <= idx_s;
            cnt_r     <= cnt_s;
            coin_r    <= coin_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            timeout_r <= timeout_s;
            error_r   <= error_s;
            paid_r    <= paid_s;
        end
    end

    assign bus.coin    = coin_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.timeout = timeout_r;
    assign bus.error   = error_r;
    assign bus.paid    = paid_r;

endmodule

// File: tb/tb_coin_feeder.sv
// tb_coin_feeder
//   Directed testbench for coin_feeder with HOLD=1, GAP=2, WAIT=4.
//   Outputs are packed as {coin, busy, done, timeout, error, paid} and
//   compared one cycle at a time against hand-computed values.
module tb_coin_feeder;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    coin_feeder_if bus ();

    coin_feeder #(
        .HOLD_CYCLES (1),
        .GAP_CYCLES  (2),
        .WAIT_CYCLES (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [10:0] pk(input logic [1:0] c, input logic b, input logic d,
                                       input logic t, input logic e, input logic [4:0] p);
        return {c, b, d, t, e, p};
    endfunction

    function automatic logic [10:0] obs();
        return {bus.coin, bus.busy, bus.done, bus.timeout, bus.error, bus.paid};
    endfunction

    function automatic string fmt(input logic [10:0] v);
        return $sformatf("coin=%0d busy=%b done=%b timeout=%b error=%b paid=%0d",
                         v[10:9], v[8], v[7], v[6], v[5], v[4:0]);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] exp;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.plan = 2'd0;
        bus.newspaper = 1'b0;
        tick();
        tick();
        exp = pk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL reset: got %s expected %s", fmt(obs()), fmt(exp));
        end
    endtask

    // Plan 0 accepted on the first edge after reset release, done on first WAIT cycle.
    task automatic test_plan0_done();
        logic [1:0]  cs [0:8];
        logic [4:0]  ps [0:8];
        logic [10:0] exp;
        cs = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
        ps = '{5'd5, 5'd5, 5'd5, 5'd10, 5'd10, 5'd10, 5'd15, 5'd15, 5'd15};
        reset = 1'b1;
        bus.start = 1'b1;
        bus.plan = 2'd0;
        tick();
        bus.start = 1'b0;
        bus.plan = 2'd3;
        for (int i = 0; i < 9; i++) begin
            exp = pk(cs[i], 1'b1, 1'b0, 1'b0, 1'b0, ps[i]);
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL plan0[%0d]: got %s expected %s", i, fmt(obs()), fmt(exp));
            end
            tick();
        end
        exp = pk(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd15);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL plan0_wait: got %s expected %s", fmt(obs()), fmt(exp));
        end
        bus.newspaper = 1'b1;
        tick();
        bus.newspaper = 1'b0;
        exp = pk(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd15);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL plan0_done: got %s expected %s", fmt(obs()), fmt(exp));
        end
        tick();
        exp = pk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd15);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL plan0_after: got %s expected %s", fmt(obs()), fmt(exp));
        end
    endtask

    // Plan 3, newspaper during second dime DRIVE; start on the returning edge is ignored.
    task automatic test_plan3_done();
        logic [1:0]  cs [0:3];
        logic [4:0]  ps [0:3];
        logic [10:0] exp;
        cs = '{2'd2, 2'd0, 2'd0, 2'd2};
        ps = '{5'd10, 5'd10, 5'd10, 5'd20};
        bus.start = 1'b1;
        bus.plan = 2'd3;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp = pk(cs[i], 1'b1, 1'b0, 1'b0, 1'b0, ps[i]);
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL plan3[%0d]: got %s expected %s", i, fmt(obs()), fmt(exp));
            end
            if (i < 3) begin
                tick();
            end else begin
                bus.newspaper = 1'b1;
                bus.start = 1'b1;
                bus.plan = 2'd1;
                tick();
            end
        end
        bus.newspaper = 1'b0;
        exp = pk(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd20);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL plan3_done: got %s expected %s", fmt(obs()), fmt(exp));
        end
    endtask

    // Start still high one cycle after returning to IDLE is accepted.
    task automatic test_back_to_back();
        logic [10:0] exp;
        tick();
        bus.start = 1'b0;
        exp = pk(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL back_to_back: got %s expected %s", fmt(obs()), fmt(exp));
        end
    endtask

    // Plan 1 (already running), newspaper never arrives.
    task automatic test_timeout();
        logic [1:0]  cs [0:5];
        logic [4:0]  ps [0:5];
        logic [10:0] exp;
        cs = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0};
        ps = '{5'd5, 5'd5, 5'd5, 5'd15, 5'd15, 5'd15};
        for (int i = 0; i < 6; i++) begin
            exp = pk(cs[i], 1'b1, 1'b0, 1'b0, 1'b0, ps[i]);
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL plan1[%0d]: got %s expected %s", i, fmt(obs()), fmt(exp));
            end
            tick();
        end
        for (int w = 0; w < 4; w++) begin
            exp = pk(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd15);
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL wait[%0d]: got %s expected %s", w, fmt(obs()), fmt(exp));
            end
            tick();
        end
        exp = pk(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd15);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL timeout_pulse: got %s expected %s", fmt(obs()), fmt(exp));
        end
        tick();
        exp = pk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd15);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL timeout_after: got %s expected %s", fmt(obs()), fmt(exp));
        end
    endtask

    // Newspaper in IDLE changes nothing.
    task automatic test_idle_newspaper();
        logic [10:0] exp;
        bus.newspaper = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp = pk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd15);
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL idle_news[%0d]: got %s expected %s", i, fmt(obs()), fmt(exp));
            end
        end
        bus.newspaper = 1'b0;
    endtask

    // Plan 0, newspaper in the first GAP -> error, no further coins.
    task automatic test_error();
        logic [10:0] exp;
        bus.start = 1'b1;
        bus.plan = 2'd0;
        tick();
        bus.start = 1'b0;
        tick();
        exp = pk(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL err_gap: got %s expected %s", fmt(obs()), fmt(exp));
        end
        bus.newspaper = 1'b1;
        tick();
        bus.newspaper = 1'b0;
        exp = pk(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL err_pulse: got %s expected %s", fmt(obs()), fmt(exp));
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = pk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5);
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL err_after[%0d]: got %s expected %s", i, fmt(obs()), fmt(exp));
            end
        end
    endtask

    // Plan 2, reset during the second DRIVE aborts silently.
    task automatic test_reset_mid();
        logic [10:0] exp;
        bus.start = 1'b1;
        bus.plan = 2'd2;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        exp = pk(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd15);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL rst_mid_drive2: got %s expected %s", fmt(obs()), fmt(exp));
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp = pk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL rst_mid: got %s expected %s", fmt(obs()), fmt(exp));
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL rst_mid_after[%0d]: got %s expected %s", i, fmt(obs()), fmt(exp));
            end
        end
    endtask

    // Plan 2, second start with plan 0 mid-sequence is ignored.
    task automatic test_restart_ignored();
        logic [1:0]  cs [0:7];
        logic [4:0]  ps [0:7];
        logic [10:0] exp;
        cs = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
        ps = '{5'd10, 5'd10, 5'd10, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15};
        bus.start = 1'b1;
        bus.plan = 2'd2;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = pk(cs[i], 1'b1, 1'b0, 1'b0, 1'b0, ps[i]);
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL restart[%0d]: got %s expected %s", i, fmt(obs()), fmt(exp));
            end
            bus.start = (i == 1) ? 1'b1 : 1'b0;
            bus.plan = 2'd0;
            bus.newspaper = (i == 7) ? 1'b1 : 1'b0;
            tick();
        end
        bus.newspaper = 1'b0;
        exp = pk(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd15);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL restart_done: got %s expected %s", fmt(obs()), fmt(exp));
        end
        tick();
        exp = pk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd15);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL restart_after: got %s expected %s", fmt(obs()), fmt(exp));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_plan0_done();
        test_plan3_done();
        test_back_to_back();
        test_timeout();
        test_idle_newspaper();
        test_error();
        test_reset_mid();
        test_restart_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coin_feeder.md
COIN_FEEDER -- requirements
Module: coin_feeder

Interface
REQ-001 Parameter HOLD_CYCLES, default 1: clock cycles each coin code is held on coin.
REQ-002 Parameter GAP_CYCLES, default 2: clock cycles coin is held at 0 after each coin.
REQ-003 Parameter WAIT_CYCLES, default 4: cycles allowed in WAIT for newspaper after the final gap.
REQ-004 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-low reset.
REQ-006 Port start, input, 1: request one purchase; sampled only in IDLE.
REQ-007 Port plan, input, 2: payment plan, latched on start accept.
- 0 = nickel, nickel, nickel
- 1 = nickel, dime
- 2 = dime, nickel
- 3 = dime, dime
REQ-008 Port newspaper, input, 1: dispense indication from the vending machine.
REQ-009 Port coin, output, 2: 0 = none, 1 = nickel, 2 = dime; 3 is never driven.
REQ-010 Port busy, output, 1: high in every state except IDLE.
REQ-011 Port done, output, 1: one-cycle pulse when the purchase succeeds.
REQ-012 Port timeout, output, 1: one-cycle pulse when no newspaper arrives within the window.
REQ-013 Port error, output, 1: one-cycle pulse when newspaper arrives before the final coin is driven.
REQ-014 Port paid, output, 5: cents inserted in the current or last purchase, 0..20.

Function
REQ-015 States SHALL be exactly IDLE, DRIVE, GAP and WAIT; all outputs SHALL be registered.
REQ-016 IDLE with start=1 at edge k SHALL:
- latch plan and clear the coin index;
- clear paid;
- enter DRIVE so that coin carries the first code and busy=1 from edge k onward.
REQ-017 DRIVE SHALL hold coin at the current code for HOLD_CYCLES cycles.
REQ-018 paid SHALL increase by 5 (nickel) or 10 (dime) at the edge that enters DRIVE for that coin.
REQ-019 On HOLD expiry, the next state SHALL be GAP with coin=0.
REQ-020 GAP SHALL last GAP_CYCLES cycles; on expiry:
- next state DRIVE with the next code if coins remain;
- otherwise next state WAIT.
REQ-021 The sequence length SHALL be 3 coins for plan 0 and 2 coins for plans 1-3.
REQ-022 newspaper=1 sampled in the final coin's DRIVE, in the final GAP, or in WAIT SHALL produce:
- done=1 for one cycle, coin=0;
- next state IDLE;
- paid held at its final value.
REQ-023 newspaper=1 sampled before the final coin's DRIVE SHALL produce:
- error=1 for one cycle, coin=0;
- next state IDLE;
- paid held at its current value.
REQ-024 WAIT with no newspaper for WAIT_CYCLES cycles SHALL produce timeout=1 for one cycle and next state IDLE.
REQ-025 start while busy=1 SHALL be ignored, and plan changes while busy SHALL have no effect.
REQ-026 IDLE with newspaper=1 SHALL produce no output change.
REQ-027 start=1 on the same edge that returns the FSM to IDLE SHALL be ignored; the next start is accepted in IDLE no earlier than one cycle later.
REQ-028 done, timeout and error SHALL be mutually exclusive and never asserted for two consecutive cycles.
REQ-029 All internal counters SHALL be wide enough for their parameter value and SHALL never wrap.

Reset
REQ-030 reset=0 at any rising edge SHALL, at that edge and regardless of state:
- force state IDLE;
- drive coin=0, busy=0, done=0, timeout=0, error=0, paid=0;
- clear all counters and the latched plan.
REQ-031 Reset asserted mid-operation SHALL abort the purchase with no done, timeout or error pulse.
REQ-032 After reset is released, start SHALL be accepted on the first following edge with reset=1.

Verification (HOLD=1, GAP=2, WAIT=4)
REQ-033 Plan 0, start pulse, newspaper=1 on the first WAIT cycle -> coin per cycle 1,0,0,1,0,0,1,0,0; done pulse; paid=15.
REQ-034 Plan 3, newspaper=1 during the second dime's DRIVE -> coin 2,0,0,2; done on the next cycle; paid=20; busy=0 after.
REQ-035 Plan 1, newspaper held 0 -> coin 1,0,0,2,0,0; 4 WAIT cycles; timeout pulse; paid=15.
REQ-036 Plan 0, newspaper=1 in the first GAP -> error pulse; coin=0; paid=5; no further coins.
REQ-037 Plan 2, reset=0 during the second DRIVE -> coin=0 and paid=0 at that edge; no pulses.
REQ-038 Plan 2, start re-pulsed with plan=0 mid-sequence -> second start ignored; coin sequence 2,0,0,1; paid=15.
